// File: rtl/ro_puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF reader.
package ro_puf_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int DEF_NUM_RO = 16;
  localparam int DEF_WINDOW = 1024;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one raw oscillator, detects rising edges and counts them
// into a saturating counter gated by clear and count-enable.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clear_i,
  input  logic             cnt_en_i,
  output logic [CNT_W-1:0] count_o
);
  logic             sync1_q, sync2_q, hist_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rise = sync2_q & ~hist_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/ro_puf_reader.sv
// Enables two challenge-selected oscillators, counts their edges over a fixed
// window and reports which one ran faster.
module ro_puf_reader
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO = DEF_NUM_RO,
  parameter int SEL_W  = $clog2(NUM_RO),
  parameter int WINDOW = DEF_WINDOW,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
  input  logic              start,
  input  logic [SEL_W-1:0]  chal_a,
  input  logic [SEL_W-1:0]  chal_b,
  output logic              busy,
  output logic              done,
  output logic              response,
  output logic              equal,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b,
  output state_e            state_dbg
);
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [SEL_W-1:0]   sel_a_q, sel_b_q;
  logic               response_q, equal_q;
  logic [CNT_W-1:0]   count_a_q, count_b_q;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic               ro_a, ro_b;
  logic               enabled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE - 1)) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (tmr_q == TMR_W'(WINDOW - 1)) begin
          state_d = ST_COMPARE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_COMPARE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Out-of-range indices match no bit, so they neither enable nor feed a counter.
  always_comb begin
    enabled = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    ro_en   = '0;
    ro_a    = 1'b0;
    ro_b    = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (enabled && ((int'(sel_a_q) == i) || (int'(sel_b_q) == i))) ro_en[i] = 1'b1;
      if (int'(sel_a_q) == i) ro_a = ro_in[i];
      if (int'(sel_b_q) == i) ro_b = ro_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      response_q <= 1'b0;
      equal_q    <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        sel_a_q <= chal_a;
        sel_b_q <= chal_b;
      end
      if (state_q == ST_COMPARE) begin
        response_q <= (cnt_a > cnt_b);
        equal_q    <= (cnt_a == cnt_b);
        count_a_q  <= cnt_a;
        count_b_q  <= cnt_b;
      end
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst      (rst),
    .ro_i     (ro_a),
    .clear_i  (state_q == ST_SETTLE),
    .cnt_en_i (state_q == ST_MEASURE),
    .count_o  (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst      (rst),
    .ro_i     (ro_b),
    .clear_i  (state_q == ST_SETTLE),
    .cnt_en_i (state_q == ST_MEASURE),
    .count_o  (cnt_b)
  );

  assign response  = response_q;
  assign equal     = equal_q;
  assign count_a   = count_a_q;
  assign count_b   = count_b_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_ro_puf_reader.sv
// Directed bench for ro_puf_reader: a main instance (WINDOW=64) and a
// narrow-counter instance (CNT_W=4, WINDOW=128) share clock, reset and ro_in.
module tb_ro_puf_reader;
  import ro_puf_pkg::*;

  localparam int NUM_RO   = 16;
  localparam int SETTLE   = 4;
  localparam int WINDOW   = 64;
  localparam int S_WINDOW = 128;

  typedef struct packed {
    logic        resp;
    logic        eq;
    logic [15:0] ca;
    logic [15:0] cb;
    logic [7:0]  tol_a;
    logic [7:0]  tol_b;
    logic [31:0] done_cyc;
  } exp_t;

  logic              clk, rst;
  logic [NUM_RO-1:0] ro_in;
  logic              start, busy, done, response, equal;
  logic [3:0]        chal_a, chal_b;
  logic [NUM_RO-1:0] ro_en;
  logic [15:0]       count_a, count_b;
  state_e            state_dbg;

  logic              s_start, s_busy, s_done, s_response, s_equal;
  logic [3:0]        s_chal_a, s_chal_b;
  logic [NUM_RO-1:0] s_ro_en;
  logic [3:0]        s_count_a, s_count_b;
  state_e            s_state_dbg;

  exp_t exp_q[$];
  exp_t exp_s_q[$];
  int   checks, errors;
  int   cyc;
  int   half[NUM_RO];

  ro_puf_reader #(.NUM_RO(NUM_RO), .WINDOW(WINDOW), .SETTLE(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .ro_en(ro_en), .start(start),
    .chal_a(chal_a), .chal_b(chal_b), .busy(busy), .done(done),
    .response(response), .equal(equal), .count_a(count_a), .count_b(count_b),
    .state_dbg(state_dbg)
  );

  ro_puf_reader #(.NUM_RO(NUM_RO), .WINDOW(S_WINDOW), .SETTLE(SETTLE), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ro_in(ro_in), .ro_en(s_ro_en), .start(s_start),
    .chal_a(s_chal_a), .chal_b(s_chal_b), .busy(s_busy), .done(s_done),
    .response(s_response), .equal(s_equal), .count_a(s_count_a), .count_b(s_count_b),
    .state_dbg(s_state_dbg)
  );

  // Clock / reset / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void chk_tol(input string name, input int act, input int exp, input int tol);
    checks++;
    if ((act < exp - tol) || (act > exp + tol)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d+-%0d", name, act, exp, tol);
    end
  endfunction

  // Oscillator model: bit i toggles every half[i] clk cycles (0 = static).
  initial begin
    int gcnt;
    gcnt  = 0;
    ro_in = '0;
    for (int i = 0; i < NUM_RO; i++) half[i] = 0;
    half[1] = 1;
    half[2] = 8;
    half[3] = 2;
    half[5] = 3;
    half[7] = 4;
    forever begin
      @(negedge clk);
      gcnt++;
      for (int i = 0; i < NUM_RO; i++)
        if ((half[i] != 0) && (gcnt % half[i] == 0)) ro_in[i] = ~ro_in[i];
    end
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, int'(e.done_cyc));
        chk("response", int'(response), int'(e.resp));
        chk("equal", int'(equal), int'(e.eq));
        chk_tol("count_a", int'(count_a), int'(e.ca), int'(e.tol_a));
        chk_tol("count_b", int'(count_b), int'(e.cb), int'(e.tol_b));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && s_done) begin
      if (exp_s_q.size() == 0) begin
        chk("sat_unexpected_done", 1, 0);
      end else begin
        e = exp_s_q.pop_front();
        chk("sat_done_cycle", cyc, int'(e.done_cyc));
        chk("sat_response", int'(s_response), int'(e.resp));
        chk("sat_equal", int'(s_equal), int'(e.eq));
        chk_tol("sat_count_a", int'(s_count_a), int'(e.ca), int'(e.tol_a));
        chk_tol("sat_count_b", int'(s_count_b), int'(e.cb), int'(e.tol_b));
      end
    end
  end

  // Driver: one full transaction on the main instance, optionally poking a
  // second start while busy. Checks ro_en/busy through SETTLE and MEASURE.
  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input exp_t e,
                         input logic [NUM_RO-1:0] mask, input bit poke);
    int t0;
    bit en_ok;
    @(negedge clk);
    chal_a = a;
    chal_b = b;
    start  = 1'b1;
    t0     = cyc;
    e.done_cyc = 32'(t0 + SETTLE + WINDOW + 2);
    exp_q.push_back(e);
    en_ok = 1'b1;
    for (int k = 1; k <= SETTLE + WINDOW; k++) begin
      @(negedge clk);
      if (poke && (k == 10)) begin
        start  = 1'b1;
        chal_a = 4'd1;
        chal_b = 4'd2;
      end else begin
        start = 1'b0;
      end
      if ((ro_en !== mask) || (busy !== 1'b1)) en_ok = 1'b0;
    end
    chk("ro_en_busy_window", int'(en_ok), 1);
    @(negedge clk);
    chk("ro_en_compare", int'(ro_en), 0);
    @(negedge clk);
    chk("busy_in_done", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("busy_after", int'(busy), 0);
    chk("response_hold", int'(response), int'(e.resp));
  endtask

  function automatic exp_t mk(input logic r, input logic q, input int ca, input int cb,
                              input int ta, input int tb);
    exp_t e;
    e.resp     = r;
    e.eq       = q;
    e.ca       = 16'(ca);
    e.cb       = 16'(cb);
    e.tol_a    = 8'(ta);
    e.tol_b    = 8'(tb);
    e.done_cyc = '0;
    return e;
  endfunction

  initial begin
    exp_t e;
    int   t0;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    chal_a  = '0;
    chal_b  = '0;
    s_start = 1'b0;
    s_chal_a = '0;
    s_chal_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ro_en", int'(ro_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_response", int'(response), 0);
    chk("rst_equal", int'(equal), 0);
    chk("rst_counts", int'(count_a) + int'(count_b), 0);
    chk("rst_state", int'(state_dbg), int'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A fast (16 edges), B slow (8 edges)
    run_txn(4'd3, 4'd7, mk(1'b1, 1'b0, 16, 8, 1, 1), 16'h0088, 1'b0);
    // Swapped challenge
    run_txn(4'd7, 4'd3, mk(1'b0, 1'b0, 8, 16, 1, 1), 16'h0088, 1'b0);
    // Same oscillator twice: identical counts
    run_txn(4'd5, 4'd5, mk(1'b0, 1'b1, 11, 11, 1, 1), 16'h0020, 1'b0);
    // Start while busy must be ignored
    run_txn(4'd3, 4'd7, mk(1'b1, 1'b0, 16, 8, 1, 1), 16'h0088, 1'b1);

    // Reset mid-measurement
    @(negedge clk);
    chal_a = 4'd3;
    chal_b = 4'd7;
    start  = 1'b1;
    t0     = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + SETTLE + 20) @(negedge clk);
    chk("pre_rst_ro_en", int'(ro_en), 16'h0088);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ro_en", int'(ro_en), 0);
    chk("mid_rst_counts", int'(count_a) + int'(count_b), 0);
    chk("mid_rst_state", int'(state_dbg), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(4'd3, 4'd7, mk(1'b1, 1'b0, 16, 8, 1, 1), 16'h0088, 1'b0);

    // Narrow counters: A saturates at 15, B slow
    @(negedge clk);
    s_chal_a = 4'd1;
    s_chal_b = 4'd2;
    s_start  = 1'b1;
    e = mk(1'b1, 1'b0, 15, 8, 0, 1);
    e.done_cyc = 32'(cyc + SETTLE + S_WINDOW + 2);
    exp_s_q.push_back(e);
    @(negedge clk);
    s_start = 1'b0;
    chk("sat_ro_en", int'(s_ro_en), 16'h0006);
    for (int k = 0; k < 400 && exp_s_q.size() != 0; k++) @(negedge clk);
    chk("sat_pending", exp_s_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("main_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
